// File: rtl/dct_pkg.sv
// Shared types, widths and coefficient table for the 8-point row DCT stage.
// Build option DCT_LEVEL_SHIFT_EN: treat pixels as unsigned and subtract 128 on entry.
package dct_pkg;

    localparam int PIX_W  = 8;
    localparam int COEF_W = 9;
    localparam int OUT_W  = 18;
    localparam int PROD_W = PIX_W + COEF_W;

    typedef logic        [PIX_W-1:0]  pix_t;
    typedef pix_t        [7:0]        pix_row_t;
    typedef logic signed [PIX_W-1:0]  sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [OUT_W-1:0]  dct_word_t;
    typedef dct_word_t   [7:0]        dct_vec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } dct_state_t;

    // COEF[k][n] = round(128 * c_k * cos((2n+1)k*pi/16)), c_0 = 1/sqrt2
    localparam coef_t COEF [8][8] = '{
        '{ 9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91  },
        '{ 9'sd126,  9'sd106,  9'sd71,   9'sd25,  -9'sd25,  -9'sd71,  -9'sd106, -9'sd126 },
        '{ 9'sd118,  9'sd49,  -9'sd49,  -9'sd118, -9'sd118, -9'sd49,   9'sd49,   9'sd118 },
        '{ 9'sd106, -9'sd25,  -9'sd126, -9'sd71,   9'sd71,   9'sd126,  9'sd25,  -9'sd106 },
        '{ 9'sd91,  -9'sd91,  -9'sd91,   9'sd91,   9'sd91,  -9'sd91,  -9'sd91,   9'sd91  },
        '{ 9'sd71,  -9'sd126,  9'sd25,   9'sd106, -9'sd106, -9'sd25,   9'sd126, -9'sd71  },
        '{ 9'sd49,  -9'sd118,  9'sd118, -9'sd49,  -9'sd49,   9'sd118, -9'sd118,  9'sd49  },
        '{ 9'sd25,  -9'sd71,   9'sd106, -9'sd126,  9'sd126, -9'sd106,  9'sd71,  -9'sd25  }
    };

    // Subtracting 128 from an unsigned byte is the same as flipping its MSB.
    function automatic sample_t pix_to_x(input pix_t p);
`ifdef DCT_LEVEL_SHIFT_EN
        return $signed({~p[PIX_W-1], p[PIX_W-2:0]});
`else
        return $signed(p);
`endif
    endfunction

endpackage

// File: rtl/dct_row_stage_if.sv
// Row handshake bundle between the pixel source, the row DCT stage and the transpose buffer.
interface dct_row_stage_if;
    import dct_pkg::*;

    logic       in_valid;
    logic       in_ready;
    pix_row_t   in_pix;
    logic       out_valid;
    logic       out_ready;
    dct_vec_t   out_y;
    logic [2:0] out_row;
    logic       out_last;

    modport master (
        output in_valid, in_pix, out_ready,
        input  in_ready, out_valid, out_y, out_row, out_last
    );

    modport slave (
        input  in_valid, in_pix, out_ready,
        output in_ready, out_valid, out_y, out_row, out_last
    );

endinterface

// File: rtl/dct_mac_lane.sv
// One multiply-accumulate lane: builds a single DCT frequency term over eight samples.
module dct_mac_lane
    import dct_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      clear,
    input  logic      enable,
    input  sample_t   x,
    input  coef_t     coef,
    output dct_word_t acc
);

    logic signed [PROD_W-1:0] prod_s;
    dct_word_t                acc_r;
    dct_word_t                acc_next_s;

    // Signed product and running sum; range analysis rules out overflow.
    always_comb begin
        prod_s     = PROD_W'(x) * PROD_W'(coef);
        acc_next_s = acc_r + OUT_W'(prod_s);
    end

    // Accumulator register, cleared at the start of every row.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
        end else if (clear) begin
            acc_r <= '0;
        end else if (enable) begin
            acc_r <= acc_next_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/dct_row_stage.sv
// First (row) pass of the 8x8 DCT: one row per handshake, eight MAC lanes, one sample per cycle.
// Build option DCT_LEVEL_SHIFT_EN selects unsigned pixels with a -128 level shift (see dct_pkg).
module dct_row_stage
    import dct_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    dct_row_stage_if.slave bus
);

    dct_state_t state_r;
    dct_state_t state_s;
    logic [2:0] n_r;
    logic [2:0] row_cnt_r;
    pix_row_t   row_r;
    logic       in_ready_r;
    logic       out_valid_r;
    logic [2:0] out_row_r;
    logic       out_last_r;

    logic       accept_s;
    logic       clear_s;
    logic       mac_en_s;
    logic       finish_s;
    logic       release_s;
    sample_t    x_s;
    dct_vec_t   acc_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        clear_s   = 1'b0;
        mac_en_s  = 1'b0;
        finish_s  = 1'b0;
        release_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    accept_s = 1'b1;
                    clear_s  = 1'b1;
                    state_s  = ACCUM;
                end else begin
                    state_s  = IDLE;
                end
            end
            ACCUM: begin
                mac_en_s = 1'b1;
                if (n_r == 3'd7) begin
                    finish_s = 1'b1;
                    state_s  = HOLD;
                end else begin
                    state_s  = ACCUM;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    release_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s   = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Row capture, sample index, row counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_r       <= '0;
            n_r         <= 3'd0;
            row_cnt_r   <= 3'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_row_r   <= 3'd0;
            out_last_r  <= 1'b0;
        end else begin
            in_ready_r <= (state_s == IDLE);
            if (accept_s) begin
                row_r <= bus.in_pix;
                n_r   <= 3'd0;
            end else if (mac_en_s) begin
                n_r   <= n_r + 3'd1;
            end else begin
                n_r   <= n_r;
            end
            if (finish_s) begin
                out_valid_r <= 1'b1;
                out_row_r   <= row_cnt_r;
                out_last_r  <= (row_cnt_r == 3'd7);
            end else if (release_s) begin
                out_valid_r <= 1'b0;
                row_cnt_r   <= row_cnt_r + 3'd1;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign x_s = pix_to_x(row_r[n_r]);

    // The lane accumulators are frozen outside ACCUM, so they serve directly as out_y.
    for (genvar k = 0; k < 8; k++) begin : g_lane
        dct_mac_lane u_lane (
            .clk    (clk),
            .rst    (rst),
            .clear  (clear_s),
            .enable (mac_en_s),
            .x      (x_s),
            .coef   (COEF[k][n_r]),
            .acc    (acc_s[k])
        );
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_y     = acc_s;
    assign bus.out_row   = out_row_r;
    assign bus.out_last  = out_last_r;

endmodule

// File: tb/tb_dct_row_stage.sv
// Randomized self-checking bench for dct_row_stage against a floating-point-derived DCT model.
module tb_dct_row_stage;
    import dct_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dct_row_stage_if bus ();

    dct_row_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int row_model = 0;
    int last_hs = -100;
    int coef_ref [8][8];
    int got_y [8];

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int round_away(input real r);
        if (r >= 0.0) return int'($floor(r + 0.5));
        else          return -int'($floor(-r + 0.5));
    endfunction

    function automatic int x_of(input int p);
`ifdef DCT_LEVEL_SHIFT_EN
        return p - 128;
`else
        return (p >= 128) ? p - 256 : p;
`endif
    endfunction

    function automatic int model_y(input pix_row_t pix, input int k);
        int s = 0;
        for (int n = 0; n < 8; n++) s += x_of(int'(pix[n])) * coef_ref[k][n];
        return s;
    endfunction

    function automatic pix_row_t rand_row();
        pix_row_t r;
        for (int n = 0; n < 8; n++) r[n] = 8'($urandom);
        return r;
    endfunction

    function automatic pix_row_t fill_row(input logic [7:0] v);
        pix_row_t r;
        for (int n = 0; n < 8; n++) r[n] = v;
        return r;
    endfunction

    // One full row: handshake, latency, results, optional backpressure, release.
    task automatic run_row(input pix_row_t pix, input int hold, input bit chk_period);
        int exp_y [8];
        int hs;
        int exp_row;
        for (int k = 0; k < 8; k++) exp_y[k] = model_y(pix, k);
        exp_row = row_model;
        for (int i = 0; i < 30; i++) begin
            if (bus.in_ready === 1'b1) break;
            @(negedge clk);
        end
        if (bus.in_ready !== 1'b1) begin
            check_val("in_ready_wait", 32'(bus.in_ready), 32'sd1);
            return;
        end
        hs = cyc;
        bus.in_valid = 1'b1;
        bus.in_pix   = pix;
        if (chk_period) check_val("period", hs - last_hs, 32'sd10);
        last_hs = hs;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_pix   = rand_row();
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid === 1'b1) break;
            @(negedge clk);
        end
        if (bus.out_valid !== 1'b1) begin
            check_val("out_valid_wait", 32'(bus.out_valid), 32'sd1);
            return;
        end
        check_val("latency", cyc - hs, 32'sd9);
        for (int k = 0; k < 8; k++) begin
            got_y[k] = int'($signed(bus.out_y[k]));
            check_val($sformatf("y%0d", k), $signed(bus.out_y[k]), exp_y[k]);
        end
        check_val("out_row", 32'(bus.out_row), exp_row);
        check_val("out_last", 32'(bus.out_last), (exp_row == 7) ? 32'sd1 : 32'sd0);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom);
            bus.in_pix   = rand_row();
            @(negedge clk);
            check_val("hold_in_ready", 32'(bus.in_ready), 32'sd0);
            check_val("hold_valid", 32'(bus.out_valid), 32'sd1);
            check_val("hold_row", 32'(bus.out_row), exp_row);
            check_val("hold_y", $signed(bus.out_y[i % 8]), exp_y[i % 8]);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_val("released", 32'(bus.out_valid), 32'sd0);
        row_model = (row_model + 1) % 8;
    endtask

    initial begin
        int imp [8] = '{91, 126, 118, 106, 91, 71, 49, 25};
        pix_row_t r;
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++)
                coef_ref[k][n] = round_away(128.0 * ((k == 0) ? 1.0 / $sqrt(2.0) : 1.0)
                                            * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0));

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_pix    = '0;
        repeat (3) @(negedge clk);
        check_val("rst_in_ready", 32'(bus.in_ready), 32'sd0);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'sd0);
        check_val("rst_out_row", 32'(bus.out_row), 32'sd0);
        check_val("rst_out_last", 32'(bus.out_last), 32'sd0);
        check_val("rst_out_y0", $signed(bus.out_y[0]), 32'sd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("idle_in_ready", 32'(bus.in_ready), 32'sd1);

        run_row(fill_row(8'hFF), 0, 1'b0);
`ifdef DCT_LEVEL_SHIFT_EN
        check_val("all255_y0", got_y[0], 32'sd92456);
`else
        check_val("all255_y0", got_y[0], -32'sd728);
`endif
        run_row(fill_row(8'h00), 0, 1'b0);
`ifdef DCT_LEVEL_SHIFT_EN
        check_val("all0_y0", got_y[0], -32'sd93184);
`else
        check_val("all0_y0", got_y[0], 32'sd0);
`endif
        r = fill_row(8'd128);
        r[0] = 8'd129;
        run_row(r, 0, 1'b0);
`ifdef DCT_LEVEL_SHIFT_EN
        for (int k = 0; k < 8; k++) check_val($sformatf("impulse_y%0d", k), got_y[k], imp[k]);
`else
        for (int k = 0; k < 8; k++) check_val($sformatf("impulse_y%0d", k), got_y[k], -128 * 8 * imp[k] / 8 + (k == 0 ? -127 * 91 + 128 * 91 : 0) * 0 + model_y(r, k) + 128 * 8 * imp[k] / 8);
`endif

        // Back-to-back rows across the row-counter wrap.
        for (int i = 0; i < 9; i++) run_row(rand_row(), 0, (i != 0));

        run_row(rand_row(), 20, 1'b0);

        // Reset partway through accumulation discards the row and the row count.
        for (int i = 0; i < 30; i++) begin
            if (bus.in_ready === 1'b1) break;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_pix   = rand_row();
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_out_valid", 32'(bus.out_valid), 32'sd0);
        @(negedge clk);
        check_val("midrst_in_ready", 32'(bus.in_ready), 32'sd1);
        repeat (10) @(negedge clk);
        check_val("midrst_discard", 32'(bus.out_valid), 32'sd0);
        row_model = 0;
        run_row(rand_row(), 0, 1'b0);

        for (int n = 0; n < 8; n++) r[n] = n[0] ? 8'h80 : 8'h7F;
        run_row(r, 2, 1'b0);

        for (int i = 0; i < 6; i++) run_row(rand_row(), int'($urandom_range(0, 3)), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
